// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared fetch widths, reset constants and FSM encoding
package fetch_ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int INST_W = 16;

    localparam logic [ADDR_W-1:0] DEF_RESET_PC = 16'h0000;
    localparam logic [INST_W-1:0] DEF_NOP_INST = 16'h0020;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FETCH    = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;
    localparam logic [1:0] ST_REDIRECT = 2'd3;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - counts unanswered imem request cycles, raises sticky timeout
module fetch_wait_timer #(
    parameter logic [3:0] MAX_WAIT = 4'd15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_wait,
    output logic o_err
);

    logic [3:0] r_cnt;
    logic       r_err;

    // Any cycle that is not a pending-request wait clears the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 4'd0;
            r_err <= 1'b0;
        end else if (!i_wait) begin
            r_cnt <= 4'd0;
        end else if (r_cnt == MAX_WAIT - 4'd1) begin
            r_cnt <= 4'd0;
            r_err <= 1'b1;
        end else if (r_cnt != 4'hF) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_err = r_err;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch FSM with stall hold, jump/branch redirect and flush
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST,
    parameter logic [3:0]        MAX_WAIT = 4'd15
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_data_i,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              flush_o,
    output logic              fetch_err_o
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_pc_out;
    logic              r_valid;
    logic              r_flush;

    logic w_redirect;
    logic w_wait;

    assign w_redirect = (jump_i | branch_i) &&
                        (r_state == ST_FETCH || r_state == ST_HOLD);
    assign w_wait     = (r_state == ST_FETCH) && !imem_ack_i && !w_redirect;

    assign imem_req_o  = (r_state == ST_FETCH);
    assign imem_addr_o = r_pc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_inst   <= NOP_INST;
            r_pc_out <= 16'h0000;
            r_valid  <= 1'b0;
            r_flush  <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            // Redirect outranks ack and stall; a coincident fetched word is dropped.
            if (w_redirect) begin
                r_pc    <= target_i;
                r_inst  <= NOP_INST;
                r_valid <= 1'b0;
                r_flush <= 1'b1;
                r_state <= ST_REDIRECT;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_FETCH;
                    ST_FETCH: begin
                        if (imem_ack_i) begin
                            r_inst   <= imem_data_i;
                            r_pc_out <= r_pc;
                            r_valid  <= 1'b1;
                            r_pc     <= next_pc(r_pc);
                            r_state  <= stall_i ? ST_HOLD : ST_FETCH;
                        end
                    end
                    ST_HOLD: begin
                        if (!stall_i) begin
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_REDIRECT: r_state <= ST_FETCH;
                    default:     r_state <= ST_IDLE;
                endcase
            end
        end
    end

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_wait  (w_wait),
        .o_err   (fetch_err_o)
    );

    assign inst_o       = r_inst;
    assign inst_valid_o = r_valid;
    assign pc_o         = r_pc_out;
    assign flush_o      = r_flush;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized check of fetch_ctrl against a behavioural model
module tb_fetch_ctrl;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] NOP    = 16'h0020;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        stall;
    logic        jump;
    logic        branch;
    logic [15:0] target;
    logic [15:0] inst;
    logic        inst_valid;
    logic [15:0] pc_out;
    logic        flush;
    logic        fetch_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: "started" after the reset bubble, "holding" while stalled,
    // "bubble" for the single cycle after a redirect.
    bit          m_started, m_hold, m_bubble;
    logic [15:0] m_pc, m_inst, m_pcout;
    bit          m_valid, m_flush, m_err;
    int          m_wait;

    fetch_ctrl dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ack_i   (imem_ack),
        .imem_data_i  (imem_data),
        .stall_i      (stall),
        .jump_i       (jump),
        .branch_i     (branch),
        .target_i     (target),
        .inst_o       (inst),
        .inst_valid_o (inst_valid),
        .pc_o         (pc_out),
        .flush_o      (flush),
        .fetch_err_o  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] word_of(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_hold = 0; m_bubble = 0;
        m_pc = RST_PC; m_inst = NOP; m_pcout = 16'h0000;
        m_valid = 0; m_flush = 0; m_err = 0; m_wait = 0;
    endtask

    task automatic model_edge();
        m_flush = 0;
        if (!m_started) begin
            m_started = 1;
        end else if (m_bubble) begin
            m_bubble = 0;
        end else if (jump || branch) begin
            m_pc = target; m_inst = NOP; m_valid = 0;
            m_flush = 1; m_bubble = 1; m_hold = 0; m_wait = 0;
        end else if (!m_hold && imem_ack) begin
            m_inst = word_of(m_pc); m_pcout = m_pc; m_valid = 1;
            m_pc = m_pc + 16'd1; m_hold = stall; m_wait = 0;
        end else if (!m_hold) begin
            m_wait++;
            if (m_wait == 15) begin
                m_err = 1;
                m_wait = 0;
            end
        end else if (!stall) begin
            m_hold = 0;
        end
    endtask

    task automatic check_all();
        check_eq("req",   {15'd0, imem_req}, {15'd0, m_started && !m_hold && !m_bubble});
        check_eq("addr",  imem_addr, m_pc);
        check_eq("inst",  inst, m_inst);
        check_eq("valid", {15'd0, inst_valid}, {15'd0, m_valid});
        check_eq("pc_o",  pc_out, m_pcout);
        check_eq("flush", {15'd0, flush}, {15'd0, m_flush});
        check_eq("err",   {15'd0, fetch_err}, {15'd0, m_err});
    endtask

    // Inputs change at the negedge; DUT and model both consume them at the next posedge.
    task automatic drive(input bit a, input bit s, input bit j, input bit b, input logic [15:0] t);
        imem_ack  = a;
        imem_data = word_of(m_pc);
        stall     = s;
        jump      = j;
        branch    = b;
        target    = t;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        imem_ack = 0; imem_data = 0; stall = 0; jump = 0; branch = 0; target = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Back-to-back acks, then a 3-cycle stall landing on the fetch of 0x0005.
        repeat (6) drive(1, 0, 0, 0, 16'h0);
        check_eq("pc_o_4", pc_out, 16'h0004);
        repeat (3) drive(1, 1, 0, 0, 16'h0);
        check_eq("hold_pc", pc_out, 16'h0005);
        repeat (2) drive(1, 0, 0, 0, 16'h0);
        check_eq("resume_pc", pc_out, 16'h0006);

        // Jump coincident with the ack of 0x0010; redirect inputs ignored in the bubble.
        for (int i = 0; i < 40 && m_pc != 16'h0010; i++) drive(1, 0, 0, 0, 16'h0);
        drive(1, 0, 1, 0, 16'h0040);
        check_eq("jump_flush", {15'd0, flush}, 16'h0001);
        drive(1, 0, 0, 1, 16'h0099);
        check_eq("bubble_addr", imem_addr, 16'h0040);
        drive(1, 0, 0, 0, 16'h0);

        // No acks: sticky timeout, stall ignored while the request is outstanding.
        for (int i = 0; i < 22; i++) drive(0, i[2], 0, 0, 16'h0);
        check_eq("err_sticky", {15'd0, fetch_err}, 16'h0001);
        drive(1, 0, 0, 0, 16'h0);

        // PC wrap at 0xFFFF.
        drive(0, 0, 0, 1, 16'hFFFE);
        drive(0, 0, 0, 0, 16'h0);
        repeat (3) drive(1, 0, 0, 0, 16'h0);
        check_eq("wrap_pc_o", pc_out, 16'h0000);

        // Asynchronous reset mid-request; late ack after release must be ignored.
        drive(0, 0, 0, 0, 16'h0);
        imem_ack = 1;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 16'h0);
        drive(1, 0, 0, 0, 16'h0);
        check_eq("post_rst_pc", pc_out, RST_PC);

        for (int i = 0; i < 500; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 16) == 0,
                  ($urandom % 16) == 0, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 16'h0020, instruction word driven on flush and reset.
REQ-003 SHALL have parameter MAX_WAIT, default 4'd15, cycles an imem request may wait before error.
REQ-004 SHALL have ports, one per line:
- clk_i  in  1  single clock, all state on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- imem_req_o  out  1  instruction-memory request, level.
- imem_addr_o  out  16  word address of current request.
- imem_ack_i  in  1  one-cycle ack; imem_data_i valid in same cycle.
- imem_data_i  in  16  fetched instruction word.
- stall_i  in  1  decode/execute hazard; hold current instruction.
- jump_i  in  1  taken jump from execute.
- branch_i  in  1  taken branch from execute.
- target_i  in  16  redirect address, valid with jump_i|branch_i.
- inst_o  out  16  instruction to instruction register.
- inst_valid_o  out  1  inst_o holds a real fetched instruction.
- pc_o  out  16  address of instruction in inst_o.
- flush_o  out  1  one-cycle pulse; drives instruction register jump/branch flush input.
- fetch_err_o  out  1  sticky imem timeout flag.

Function
REQ-005 SHALL implement FSM states IDLE, FETCH, HOLD, REDIRECT.
REQ-006 IDLE: entered only from reset; imem_req_o=0; unconditionally -> FETCH next cycle.
REQ-007 FETCH: imem_req_o=1, imem_addr_o=pc; request held, address stable, until imem_ack_i or redirect.
REQ-008 FETCH with imem_ack_i: next edge inst_o<=imem_data_i, pc_o<=pc, inst_valid_o<=1, pc<=pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000).
REQ-009 FETCH with ack and stall_i=0: stay FETCH (one instruction per cycle when memory acks same cycle).
REQ-010 FETCH with ack and stall_i=1: -> HOLD; stall_i without ack ignored while request outstanding.
REQ-011 HOLD: imem_req_o=0; inst_o, pc_o, inst_valid_o, pc frozen; stall_i=0 -> FETCH; imem_ack_i ignored.
REQ-012 Redirect = jump_i|branch_i in FETCH or HOLD: highest priority; next edge pc<=target_i, inst_o<=NOP_INST, inst_valid_o<=0, flush_o<=1, wait counter cleared, -> REDIRECT.
REQ-013 Redirect coincident with imem_ack_i: fetched word discarded, pc not incremented.
REQ-014 Redirect coincident with stall_i: redirect wins.
REQ-015 REDIRECT: exactly one cycle; imem_req_o=0; flush_o deasserts next edge; ack ignored; redirect inputs ignored; -> FETCH.
REQ-016 Redirect inputs in IDLE ignored.
REQ-017 Wait counter: 4-bit, increments each FETCH cycle with imem_req_o=1 and no ack, cleared on ack, redirect, or leaving FETCH.
REQ-018 Counter reaching MAX_WAIT: fetch_err_o<=1 (sticky until reset), counter cleared, request continues unchanged; counter saturates, never wraps.
REQ-019 Single-bit control outputs other than imem_req_o SHALL be registered; imem_req_o and imem_addr_o SHALL be decoded from registered state/pc only.

Reset
REQ-020 rst_n_i low SHALL immediately force: state IDLE, pc=RESET_PC, imem_addr_o=RESET_PC, imem_req_o=0, inst_o=NOP_INST, inst_valid_o=0, pc_o=16'h0000, flush_o=0, fetch_err_o=0, wait counter 0.
REQ-021 Reset mid-request SHALL abandon the request; a late ack after release SHALL be ignored (arrives in IDLE).

Structure
REQ-022 Shared package SHALL hold NOP_INST, RESET_PC, state encoding, and 16-bit address/instruction width constants, also used by the instruction register and datapath.
REQ-023 One sub-module SHALL be used: fetch_wait_timer (wait counter, MAX_WAIT compare, sticky error); remainder in fetch_ctrl.

Verification
REQ-024 Reset release, memory acks every request same cycle -> req rises cycle 2; inst_o tracks words at 0x0000,0x0001,0x0002 on consecutive cycles; pc_o matches.
REQ-025 stall_i high 3 cycles after fetch of 0x0005 -> HOLD; inst_o/pc_o frozen at 0x0005; imem_req_o=0; resume fetches 0x0006.
REQ-026 jump_i with target_i=0x0040 coincident with ack of 0x0010 -> word discarded; flush_o one cycle; inst_o=0x0020, inst_valid_o=0; next request addr 0x0040.
REQ-027 Memory never acks -> fetch_err_o rises after 15 waiting cycles, stays high; req held at same address; later ack accepted normally.
REQ-028 pc=0xFFFF fetched -> next request 0x0000; rst_n_i pulsed mid-request -> all outputs at REQ-020 values immediately, first request RESET_PC.
